// File: rtl/frac_mc.sv
// frac_mc: eighth-pel bilinear motion-compensation interpolator.
// Takes a fractional MV (fx, fy) per block and turns ROWS+1 integer-pel reference rows
// (9 pixels each) into ROWS predicted rows of 8 pixels, one row per accepted input row.
module frac_mc #(
  parameter int unsigned ROWS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mvx,
  input  logic [2:0]  mvy,
  input  logic [71:0] ref_pix,
  input  logic        in_valid,
  output logic [63:0] pred_pix,
  output logic        out_valid,
  output logic        last,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StStream
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  fx_q, fx_d;
  logic [2:0]  fy_q, fy_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [10:0] hprev_q [8];
  logic [10:0] hprev_d [8];
  logic [63:0] pred_q, pred_d;
  logic        out_valid_q, out_valid_d;
  logic        last_q, last_d;

  // Filter weights: (8 - frac) and frac, both fit in 4 bits.
  logic [3:0]  wx0, wy0;
  logic [10:0] hcur [8];
  logic [13:0] vsum [8];
  logic [63:0] vrow;
  logic        row_last;

  assign wx0      = 4'd8 - {1'b0, fx_q};
  assign wy0      = 4'd8 - {1'b0, fy_q};
  assign row_last = (cnt_q == 8'(ROWS - 1));

  // Horizontal filter of the incoming row; max (8*255) = 2040 fits 11 bits.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      hcur[i] = 11'(wx0) * 11'(ref_pix[8*i +: 8])
              + 11'(fx_q) * 11'(ref_pix[8*i+8 +: 8]);
    end
  end

  // Vertical blend with rounding; max 8*2040+32 = 16352 fits 14 bits, result <= 255.
  always_comb begin
    vrow = '0;
    for (int i = 0; i < 8; i++) begin
      vsum[i] = 14'(wy0) * 14'(hprev_q[i]) + 14'(fy_q) * 14'(hcur[i]) + 14'd32;
      vrow[8*i +: 8] = 8'(vsum[i] >> 6);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start only matters in idle, in_valid low simply stalls.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StPrime;
      StPrime:  if (in_valid) state_d = StStream;
      StStream: if (in_valid && row_last) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next-state: MV latch, Hprev pipeline, row counter and registered outputs.
  always_comb begin
    fx_d        = fx_q;
    fy_d        = fy_q;
    cnt_d       = cnt_q;
    hprev_d     = hprev_q;
    pred_d      = pred_q;
    out_valid_d = 1'b0;
    last_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          fx_d  = mvx;
          fy_d  = mvy;
          cnt_d = '0;
        end
      end
      StPrime: begin
        if (in_valid) begin
          hprev_d = hcur;
        end
      end
      StStream: begin
        if (in_valid) begin
          pred_d      = vrow;
          out_valid_d = 1'b1;
          last_d      = row_last;
          hprev_d     = hcur;
          cnt_d       = row_last ? 8'd0 : cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything so an aborted block leaves no trace.
  always_ff @(posedge clk) begin
    if (reset) begin
      fx_q        <= '0;
      fy_q        <= '0;
      cnt_q       <= '0;
      pred_q      <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        hprev_q[i] <= '0;
      end
    end else begin
      fx_q        <= fx_d;
      fy_q        <= fy_d;
      cnt_q       <= cnt_d;
      pred_q      <= pred_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      hprev_q     <= hprev_d;
    end
  end

  // Outputs: busy falls together with the final row's last pulse.
  always_comb begin
    pred_pix  = pred_q;
    out_valid = out_valid_q;
    last      = last_q;
    busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_frac_mc.sv
// Self-checking bench for frac_mc: scoreboard of expected rows, one task per scenario.
module tb_frac_mc;

  localparam int NR = 8;
  localparam int GAPS     = 1;
  localparam int MIDSTART = 2;
  localparam int VSTART   = 4;
  localparam int USEEXP   = 8;
  localparam int ABORT    = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mvx = '0;
  logic [2:0]  mvy = '0;
  logic [71:0] ref_pix = '0;
  logic        in_valid = 1'b0;
  logic [63:0] pred_pix;
  logic        out_valid;
  logic        last;
  logic        busy;

  typedef struct {
    logic [63:0] pix;
    logic        lst;
  } exp_t;

  exp_t        sbq [$];
  logic [71:0] rows [0:NR];
  logic [63:0] exp_rows [0:NR-1];
  int          checks = 0;
  int          errors = 0;

  frac_mc #(.ROWS(NR)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mvx      (mvx),
    .mvy      (mvy),
    .ref_pix  (ref_pix),
    .in_valid (in_valid),
    .pred_pix (pred_pix),
    .out_valid(out_valid),
    .last     (last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input int fx, input int fy,
                                        input logic [71:0] a, input logic [71:0] b);
    logic [63:0] res;
    int hp, hc, o;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      hp = (8 - fx) * int'(a[8*i +: 8]) + fx * int'(a[8*i+8 +: 8]);
      hc = (8 - fx) * int'(b[8*i +: 8]) + fx * int'(b[8*i+8 +: 8]);
      o  = ((8 - fy) * hp + fy * hc + 32) >> 6;
      res[8*i +: 8] = o[7:0];
    end
    return res;
  endfunction

  // Streams rows[0..NR] into one block and checks each output one cycle after its row.
  task automatic drive_block(input int fx, input int fy, input int flags);
    int   r, nout, guard;
    logic pushed;
    exp_t e;
    start = 1'b1;
    mvx   = fx[2:0];
    mvy   = fy[2:0];
    if ((flags & VSTART) != 0) begin
      in_valid = 1'b1;
      ref_pix  = {8'($urandom), 32'($urandom), 32'($urandom)};
    end else begin
      in_valid = 1'b0;
    end
    cyc();
    start    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got %b want 1", busy);
    end
    r = 0;
    nout = 0;
    guard = 0;
    while (r <= NR) begin
      pushed = 1'b0;
      guard++;
      if (guard > 200) begin
        errors++;
        $display("FAIL block_budget rows_sent %0d want %0d", r, NR + 1);
        break;
      end
      if ((flags & GAPS) != 0 && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        ref_pix  = rows[r];
        if (r >= 1) begin
          e.pix = ((flags & USEEXP) != 0) ? exp_rows[r-1] : model(fx, fy, rows[r-1], rows[r]);
          e.lst = (r == NR);
          sbq.push_back(e);
          pushed = 1'b1;
        end
        r++;
        if ((flags & MIDSTART) != 0 && r == 3) begin
          start = 1'b1;
          mvx   = 3'd3;
          mvy   = 3'd3;
        end
      end
      cyc();
      start    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== pushed) begin
        errors++;
        $display("FAIL out_valid_timing row %0d got %b want %b", r, out_valid, pushed);
      end
      if (out_valid === 1'b1 && sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got %h want none", pred_pix);
      end else if (out_valid === 1'b1 || pushed) begin
        e = sbq.pop_front();
        if (out_valid === 1'b1) begin
          nout++;
          checks++;
          if (pred_pix !== e.pix || last !== e.lst) begin
            errors++;
            $display("FAIL pred_row %0d got %h last %b want %h last %b",
                     nout, pred_pix, last, e.pix, e.lst);
          end
          if (e.lst) begin
            checks++;
            if (busy !== 1'b0) begin
              errors++;
              $display("FAIL busy_with_last got %b want 0", busy);
            end
          end
        end
      end
      if ((flags & ABORT) != 0 && nout == 3) begin
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if ({busy, out_valid, last} !== 3'b000 || pred_pix !== 64'd0) begin
          errors++;
          $display("FAIL abort_state got busy %b ov %b last %b pred %h want 0 0 0 0",
                   busy, out_valid, last, pred_pix);
        end
        sbq.delete();
        return;
      end
    end
  endtask

  task automatic fill_identity();
    for (int r = 0; r <= NR; r++)
      for (int i = 0; i < 9; i++) rows[r][8*i +: 8] = 8'(16 * r + i);
    for (int k = 0; k < NR; k++)
      for (int i = 0; i < 8; i++) exp_rows[k][8*i +: 8] = 8'(16 * k + i);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({busy, out_valid, last} !== 3'b000 || pred_pix !== 64'd0) begin
      errors++;
      $display("FAIL reset_state got busy %b ov %b last %b pred %h want 0 0 0 0",
               busy, out_valid, last, pred_pix);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_identity();
    fill_identity();
    drive_block(0, 0, USEEXP);
    cyc();
    cyc();
    checks++;
    if (pred_pix !== exp_rows[NR-1] || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_after_block got %h ov %b busy %b want %h 0 0",
               pred_pix, out_valid, busy, exp_rows[NR-1]);
    end
  endtask

  task automatic test_half_h();
    for (int r = 0; r <= NR; r++)
      for (int i = 0; i < 9; i++) rows[r][8*i +: 8] = 8'(16 * i);
    for (int k = 0; k < NR; k++)
      for (int i = 0; i < 8; i++) exp_rows[k][8*i +: 8] = 8'(16 * i + 8);
    drive_block(4, 0, USEEXP);
  endtask

  task automatic test_half_v();
    for (int r = 0; r <= NR; r++)
      for (int i = 0; i < 9; i++) rows[r][8*i +: 8] = 8'(10 * r);
    for (int k = 0; k < NR; k++)
      for (int i = 0; i < 8; i++) exp_rows[k][8*i +: 8] = 8'(10 * k + 5);
    drive_block(0, 4, USEEXP);
  endtask

  task automatic test_corner();
    for (int r = 0; r <= NR; r++) rows[r] = {72{1'b1}};
    for (int k = 0; k < NR; k++) exp_rows[k] = {64{1'b1}};
    drive_block(7, 7, USEEXP);
    for (int r = 0; r <= NR; r++)
      for (int i = 0; i < 9; i++) rows[r][8*i +: 8] = (((r + i) % 2) != 0) ? 8'd255 : 8'd0;
    drive_block(7, 7, 0);
  endtask

  task automatic test_gaps();
    fill_identity();
    drive_block(0, 0, USEEXP | GAPS);
    for (int r = 0; r <= NR; r++)
      for (int i = 0; i < 9; i++) rows[r][8*i +: 8] = 8'($urandom_range(0, 255));
    drive_block(5, 2, GAPS);
  endtask

  task automatic test_illegal_start();
    fill_identity();
    drive_block(0, 0, USEEXP | MIDSTART);
  endtask

  task automatic test_idle_valid();
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      ref_pix  = {8'($urandom), 32'($urandom), 32'($urandom)};
      cyc();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid got ov %b busy %b want 0 0", out_valid, busy);
      end
    end
    in_valid = 1'b0;
    fill_identity();
    drive_block(0, 0, USEEXP | VSTART);
  endtask

  task automatic test_abort();
    fill_identity();
    drive_block(0, 0, USEEXP | ABORT);
    drive_block(0, 0, USEEXP);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r <= NR; r++)
      for (int i = 0; i < 9; i++) rows[r][8*i +: 8] = 8'($urandom_range(0, 255));
    drive_block(1, 6, 0);
    drive_block(6, 1, 0);
    drive_block(2, 7, 0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_half_h();
    test_half_v();
    test_corner();
    test_gaps();
    test_illegal_start();
    test_idle_valid();
    test_abort();
    test_back_to_back();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
